// File: rtl/kbd_cmd_sequencer.sv
// Shares the PS/2 keyboard register port between the CPU and a command engine that
// resets the keyboard and programs its LEDs, with resend, timeout and retry handling.
module kbd_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter bit          AUTO_INIT      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_A,
    input  logic       cpu_CE,
    input  logic       cpu_WREN,
    input  logic       cpu_REN,
    input  logic [7:0] cpu_from,
    output logic [7:0] cpu_to,
    output logic       cpu_wait,
    output logic       kb_A,
    output logic       kb_CE,
    output logic       kb_WREN,
    output logic       kb_REN,
    output logic [7:0] kb_from_CPU,
    input  logic [7:0] kb_to_CPU,
    input  logic       init_req,
    input  logic       led_req,
    input  logic [2:0] led_val,
    output logic       busy,
    output logic       init_done,
    output logic       init_fail,
    output logic       led_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        StIdle, StSend, StSettle, StWaitTx, StWaitRx,
        StRdSetup, StRdData, StEval, StFail, StDone
    } state_e;

    typedef enum logic [1:0] {
        StepReset  = 2'd0,
        StepBat    = 2'd1,
        StepLedCmd = 2'd2,
        StepLedVal = 2'd3
    } step_e;

    state_e          state_q, state_d;
    step_e           step_q, step_d;
    logic            is_init_q, is_init_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [RW-1:0]   bat_retry_q, bat_retry_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic [2:0]      led_q, led_d;
    logic            settle_q, settle_d;
    logic            init_pend_q, init_pend_d;
    logic            led_pend_q, led_pend_d;
    logic            busy_q;
    logic            init_done_q, init_done_d;
    logic            init_fail_q, init_fail_d;
    logic            led_err_q, led_err_d;

    logic            eng_a, eng_ce, eng_wren, eng_ren;
    logic            retry_req;
    logic            wait_st;
    logic [7:0]      tx_byte;

    always_comb begin
        unique case (step_q)
            StepReset:  tx_byte = 8'hFF;
            StepBat:    tx_byte = 8'hFF;
            StepLedCmd: tx_byte = 8'hED;
            StepLedVal: tx_byte = {5'b0, led_q};
            default:    tx_byte = 8'hFF;
        endcase
    end

    assign wait_st = (state_q == StSettle) || (state_q == StWaitTx) || (state_q == StWaitRx);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        is_init_d   = is_init_q;
        retry_d     = retry_q;
        bat_retry_d = bat_retry_q;
        timer_d     = timer_q;
        rx_byte_d   = rx_byte_q;
        led_d       = led_q;
        settle_d    = settle_q;
        init_pend_d = init_pend_q | init_req;
        led_pend_d  = led_pend_q | led_req;
        init_done_d = init_done_q;
        init_fail_d = init_fail_q;
        led_err_d   = led_err_q;
        eng_a       = 1'b1;
        eng_ce      = 1'b0;
        eng_wren    = 1'b0;
        eng_ren     = 1'b0;
        retry_req   = 1'b0;

        if (wait_st && timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                // Never start while the CPU holds an access open.
                if (!cpu_CE && (init_pend_q || led_pend_q)) begin
                    state_d     = StSend;
                    is_init_d   = init_pend_q;
                    retry_d     = '0;
                    bat_retry_d = '0;
                    led_d       = led_val;
                    if (init_pend_q) begin
                        init_pend_d = init_req;
                        step_d      = StepReset;
                    end else begin
                        led_pend_d = led_req;
                        step_d     = StepLedCmd;
                    end
                end
            end
            StSend: begin
                eng_a    = 1'b0;
                eng_ce   = 1'b1;
                eng_wren = 1'b1;
                timer_d  = TW'(TIMEOUT_CYCLES);
                settle_d = 1'b0;
                state_d  = StSettle;
            end
            StSettle: begin
                if (timer_q == '0) begin
                    retry_req = 1'b1;
                end else begin
                    settle_d = 1'b1;
                    if (settle_q) state_d = StWaitTx;
                end
            end
            StWaitTx: begin
                if (timer_q == '0)     retry_req = 1'b1;
                else if (kb_to_CPU[2]) state_d = StWaitRx;
            end
            StWaitRx: begin
                if (timer_q == '0)     retry_req = 1'b1;
                else if (kb_to_CPU[3]) state_d = StRdSetup;
            end
            StRdSetup: begin
                eng_a   = 1'b0;
                state_d = StRdData;
            end
            StRdData: begin
                eng_a     = 1'b0;
                eng_ce    = 1'b1;
                eng_ren   = 1'b1;
                rx_byte_d = kb_to_CPU;
                state_d   = StEval;
            end
            StEval: begin
                if (step_q == StepBat) begin
                    if (rx_byte_q == 8'hAA) begin
                        step_d  = StepLedCmd;
                        state_d = StSend;
                    end else begin
                        retry_req = 1'b1;
                    end
                end else if (rx_byte_q == 8'hFA) begin
                    retry_d = '0;
                    unique case (step_q)
                        StepReset: begin
                            // BAT follows the ACK unprompted; give it a fresh timeout.
                            step_d  = StepBat;
                            timer_d = TW'(TIMEOUT_CYCLES);
                            state_d = StWaitRx;
                        end
                        StepLedCmd: begin
                            step_d  = StepLedVal;
                            state_d = StSend;
                        end
                        default: state_d = StDone;
                    endcase
                end else begin
                    // 0xFE and any unexpected byte both ask for a resend.
                    retry_req = 1'b1;
                end
            end
            StFail: begin
                if (is_init_q) begin
                    init_fail_d = 1'b1;
                    init_done_d = 1'b0;
                end else begin
                    led_err_d = 1'b1;
                end
                state_d = StIdle;
            end
            StDone: begin
                if (is_init_q) begin
                    init_done_d = 1'b1;
                    init_fail_d = 1'b0;
                end else begin
                    led_err_d = 1'b0;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (retry_req) begin
            if (step_q == StepBat) begin
                // A bad or missing BAT restarts the whole reset command.
                if (bat_retry_q == RW'(MAX_RETRY)) begin
                    state_d = StFail;
                end else begin
                    bat_retry_d = bat_retry_q + 1'b1;
                    retry_d     = '0;
                    step_d      = StepReset;
                    state_d     = StSend;
                end
            end else if (retry_q == RW'(MAX_RETRY)) begin
                state_d = StFail;
            end else begin
                retry_d = retry_q + 1'b1;
                state_d = StSend;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            step_q      <= StepReset;
            is_init_q   <= 1'b0;
            retry_q     <= '0;
            bat_retry_q <= '0;
            timer_q     <= '0;
            rx_byte_q   <= 8'h00;
            led_q       <= 3'b000;
            settle_q    <= 1'b0;
            init_pend_q <= AUTO_INIT;
            led_pend_q  <= 1'b0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            init_fail_q <= 1'b0;
            led_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            is_init_q   <= is_init_d;
            retry_q     <= retry_d;
            bat_retry_q <= bat_retry_d;
            timer_q     <= timer_d;
            rx_byte_q   <= rx_byte_d;
            led_q       <= led_d;
            settle_q    <= settle_d;
            init_pend_q <= init_pend_d;
            led_pend_q  <= led_pend_d;
            busy_q      <= (state_d != StIdle);
            init_done_q <= init_done_d;
            init_fail_q <= init_fail_d;
            led_err_q   <= led_err_d;
        end
    end

    always_comb begin
        if (busy_q) begin
            kb_A        = eng_a;
            kb_CE       = eng_ce;
            kb_WREN     = eng_wren;
            kb_REN      = eng_ren;
            kb_from_CPU = tx_byte;
            cpu_to      = 8'h00;
        end else begin
            kb_A        = cpu_A;
            kb_CE       = cpu_CE;
            kb_WREN     = cpu_WREN;
            kb_REN      = cpu_REN;
            kb_from_CPU = cpu_from;
            cpu_to      = kb_to_CPU;
        end
    end

    assign busy      = busy_q;
    assign cpu_wait  = busy_q;
    assign init_done = init_done_q;
    assign init_fail = init_fail_q;
    assign led_err   = led_err_q;

endmodule

// File: tb/tb_kbd_cmd_sequencer.sv
// Directed bench for kbd_cmd_sequencer with a behavioural PS/2 peripheral and keyboard.
module tb_kbd_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_A, cpu_CE, cpu_WREN, cpu_REN;
    logic [7:0] cpu_from, cpu_to;
    logic       cpu_wait;
    logic       kb_A, kb_CE, kb_WREN, kb_REN;
    logic [7:0] kb_from_CPU, kb_to_CPU;
    logic       init_req, led_req;
    logic [2:0] led_val;
    logic       busy, init_done, init_fail, led_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] wr_log[$];
    int         wr_cyc[$];
    // Keyboard script, one entry per completed transmission:
    // -1 = silent, [7:0] = reply byte, bit 8 = append BAT 0xAA.
    int         script[$];

    kbd_cmd_sequencer #(
        .TIMEOUT_CYCLES(100),
        .MAX_RETRY     (3),
        .AUTO_INIT     (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_A      (cpu_A),
        .cpu_CE     (cpu_CE),
        .cpu_WREN   (cpu_WREN),
        .cpu_REN    (cpu_REN),
        .cpu_from   (cpu_from),
        .cpu_to     (cpu_to),
        .cpu_wait   (cpu_wait),
        .kb_A       (kb_A),
        .kb_CE      (kb_CE),
        .kb_WREN    (kb_WREN),
        .kb_REN     (kb_REN),
        .kb_from_CPU(kb_from_CPU),
        .kb_to_CPU  (kb_to_CPU),
        .init_req   (init_req),
        .led_req    (led_req),
        .led_val    (led_val),
        .busy       (busy),
        .init_done  (init_done),
        .init_fail  (init_fail),
        .led_err    (led_err)
    );

    always #5 clk = ~clk;

    initial begin : kbd_model
        logic [7:0] rx_data;
        logic       rx_done, tx_done;
        logic [7:0] rx_pend[$];
        int         tx_cnt, rx_dly, cyc, e;
        rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
        tx_cnt = 0; rx_dly = 4; cyc = 0;
        kb_to_CPU <= 8'h00;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
                tx_cnt = 0; rx_dly = 4;
                rx_pend.delete();
                script.delete();
                kb_to_CPU <= 8'h00;
            end else begin
                kb_to_CPU <= kb_A ? {4'h0, rx_done, tx_done, 2'b00} : rx_data;
                if (kb_CE && kb_WREN && !kb_A) begin
                    wr_log.push_back(kb_from_CPU);
                    wr_cyc.push_back(cyc);
                    tx_done = 1'b0;
                    tx_cnt  = 5;
                end else if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin
                        tx_done = 1'b1;
                        if (script.size() > 0) begin
                            e = script.pop_front();
                            if (e >= 0) begin
                                rx_pend.push_back(e[7:0]);
                                if (e[8]) rx_pend.push_back(8'hAA);
                            end
                        end
                    end
                end
                if (kb_CE && kb_REN && !kb_A) rx_done = 1'b0;
                if (!rx_done && rx_pend.size() > 0) begin
                    if (rx_dly == 0) begin
                        rx_data = rx_pend.pop_front();
                        rx_done = 1'b1;
                        rx_dly  = 4;
                    end else begin
                        rx_dly--;
                    end
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int max_cyc, input string tag);
        int n = 0;
        while (busy !== lvl && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'b0, busy}, {31'b0, lvl});
    endtask

    task automatic check_log(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int n);
        logic [7:0] exp[3];
        exp[0] = b0; exp[1] = b1; exp[2] = b2;
        check_eq({tag, "_nwr"}, wr_log.size(), n);
        for (int i = 0; i < n && i < 3; i++) begin
            if (i < wr_log.size()) check_eq({tag, "_wr"}, {24'b0, wr_log[i]}, {24'b0, exp[i]});
        end
    endtask

    task automatic pulse(input bit is_init);
        @(negedge clk);
        if (is_init) init_req = 1'b1; else led_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        led_req  = 1'b0;
    endtask

    initial begin
        int nff;
        reset = 1'b1;
        cpu_A = 1'b0; cpu_CE = 1'b0; cpu_WREN = 1'b0; cpu_REN = 1'b0; cpu_from = 8'h00;
        init_req = 1'b0; led_req = 1'b0; led_val = 3'b000;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_wait", {31'b0, cpu_wait}, 0);
        check_eq("rst_stat", {29'b0, init_done, init_fail, led_err}, 0);
        check_eq("rst_kb", {28'b0, kb_A, kb_CE, kb_WREN, kb_REN}, 0);

        // Auto-init after release
        wr_log.delete();
        reset = 1'b0;
        script.push_back('h1FA); script.push_back('hFA); script.push_back('hFA);
        wait_busy(1'b1, 5, "auto_start");
        wait_busy(1'b0, 500, "auto_end");
        check_log("auto", 8'hFF, 8'hED, 8'h00, 3);
        check_eq("auto_done", {30'b0, init_done, init_fail}, 2'b10);

        // LED update, with first-write latency
        wr_log.delete();
        led_val = 3'b101;
        script.push_back('hFA); script.push_back('hFA);
        @(negedge clk);
        led_req = 1'b1;
        @(negedge clk);
        led_req = 1'b0;
        check_eq("led_lat_idle", {31'b0, cpu_wait}, 0);
        @(negedge clk);
        check_eq("led_lat_send", {22'b0, cpu_wait, kb_WREN, kb_from_CPU}, {2'b11, 8'hED});
        wait_busy(1'b0, 500, "led_end");
        check_log("led", 8'hED, 8'h05, 8'h00, 2);
        check_eq("led_err", {31'b0, led_err}, 0);
        check_eq("led_wait_off", {31'b0, cpu_wait}, 0);

        // Two NAKs on 0xFF, then success
        wr_log.delete();
        script.push_back('hFE); script.push_back('hFE); script.push_back('h1FA);
        script.push_back('hFA); script.push_back('hFA);
        pulse(1'b1);
        wait_busy(1'b1, 5, "nak_start");
        wait_busy(1'b0, 1000, "nak_end");
        nff = 0;
        foreach (wr_log[i]) if (wr_log[i] == 8'hFF) nff++;
        check_eq("nak_nff", nff, 3);
        check_log("nak", 8'hFF, 8'hFF, 8'hFF, 5);
        check_eq("nak_done", {30'b0, init_done, init_fail}, 2'b10);

        // Silent keyboard: four 0xFF attempts ~100 cycles apart, then failure
        wr_log.delete();
        wr_cyc.delete();
        pulse(1'b1);
        wait_busy(1'b1, 5, "to_start");
        wait_busy(1'b0, 2000, "to_end");
        check_log("to", 8'hFF, 8'hFF, 8'hFF, 4);
        for (int i = 1; i < wr_cyc.size(); i++) begin
            check_eq("to_gap", (wr_cyc[i] - wr_cyc[i-1] >= 100) && (wr_cyc[i] - wr_cyc[i-1] <= 104), 1);
        end
        check_eq("to_fail", {30'b0, init_done, init_fail}, 2'b01);

        // CPU access held open defers the engine; CPU writes blocked while busy
        wr_log.delete();
        script.push_back('hFA); script.push_back('hFA);
        @(negedge clk);
        cpu_CE = 1'b1; cpu_REN = 1'b1; cpu_A = 1'b0;
        led_req = 1'b1;
        @(negedge clk);
        led_req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("hold_idle", {31'b0, busy}, 0);
        check_eq("hold_pass", {28'b0, kb_A, kb_CE, kb_WREN, kb_REN}, 4'b0101);
        check_eq("hold_to", {24'b0, cpu_to}, {24'b0, kb_to_CPU});
        cpu_CE = 1'b0; cpu_REN = 1'b0;
        @(negedge clk);
        check_eq("hold_send", {23'b0, busy, kb_from_CPU}, {1'b1, 8'hED});
        cpu_CE = 1'b1; cpu_WREN = 1'b1; cpu_from = 8'h55;
        repeat (3) begin
            @(negedge clk);
            check_eq("hold_blk", {22'b0, kb_WREN, cpu_to == 8'h00}, 2'b01);
        end
        cpu_CE = 1'b0; cpu_WREN = 1'b0; cpu_from = 8'h00;
        wait_busy(1'b0, 500, "hold_end");
        check_log("hold", 8'hED, 8'h05, 8'h00, 2);

        // Reset during a response wait aborts; auto-init follows
        led_val = 3'b000;
        pulse(1'b0);
        wait_busy(1'b1, 5, "mid_start");
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("mid_busy", {30'b0, busy, cpu_wait}, 0);
        check_eq("mid_stat", {29'b0, init_done, init_fail, led_err}, 0);
        @(negedge clk);
        wr_log.delete();
        reset = 1'b0;
        script.push_back('h1FA); script.push_back('hFA); script.push_back('hFA);
        wait_busy(1'b1, 5, "mid_restart");
        wait_busy(1'b0, 500, "mid_end");
        check_log("mid", 8'hFF, 8'hED, 8'h00, 3);
        check_eq("mid_done", {30'b0, init_done, init_fail}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
